alu_muldiv: RTL and testbench

Multi-cycle multiply/divide unit beside the combinational ALU in the EX stage; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and performs MTHI/MTLO writes.
- Exposes busy/done so the hazard unit can stall MFHI/MFLO and further mul/div issues.
- Width is parametrised; the 32-bit MIPS datapath is the default instance.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_sign_fix.sv | 41 ++++
 rtl/alu_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and constants for the iterative
// multiply/divide unit that owns the HI/LO registers.
package muldiv_pkg;

   localparam int OPC_MULT  = 0;
   localparam int OPC_MULTU = 1;
   localparam int OPC_DIV   = 2;
   localparam int OPC_DIVU  = 3;
   localparam int OPC_MTHI  = 4;
   localparam int OPC_MTLO  = 5;

   // Divide by zero replicates this bit across LO (all ones, MIPS-style).
   localparam logic DIV0_LO_BIT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a {HI,LO} pair: either the whole
// double-width product, or HI and LO independently (quotient/remainder).
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int NB_BITS = 32
) (
   input  logic [NB_BITS-1:0] hi,
   input  logic [NB_BITS-1:0] lo,
   input  logic               pair_mode,
   input  logic               neg_hi,
   input  logic               neg_lo,
   output logic [NB_BITS-1:0] fixed_hi,
   output logic [NB_BITS-1:0] fixed_lo
);

   localparam int NB_PAIR = 2 * NB_BITS;

   logic [NB_PAIR-1:0] pair_neg;

   assign pair_neg = ~{hi, lo} + NB_PAIR'(1);

   // A product carries across the HI/LO boundary, so it is negated as one value.
   always_comb begin
      fixed_hi = hi;
      fixed_lo = lo;
      if (pair_mode) begin
         if (neg_lo) begin
            {fixed_hi, fixed_lo} = pair_neg;
         end
      end else begin
         if (neg_hi) begin
            fixed_hi = ~hi + NB_BITS'(1);
         end
         if (neg_lo) begin
            fixed_lo = ~lo + NB_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module alu_muldiv
   import muldiv_pkg::*;
#(
   parameter int NB_BITS = 32,
   parameter int NB_OPE  = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [NB_OPE-1:0]  i_ope_sel,
   input  logic [NB_BITS-1:0] i_data_a,
   input  logic [NB_BITS-1:0] i_data_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [NB_BITS-1:0] o_hi,
   output logic [NB_BITS-1:0] o_lo
);

   localparam int NB_CNT  = $clog2(NB_BITS) + 1;
   localparam int NB_PAIR = 2 * NB_BITS;

   muldiv_state_t state, next_state;

   logic [NB_CNT-1:0]  cnt;
   logic               is_div;
   logic               div_zero;
   logic               neg_hi;
   logic               neg_lo;
   logic [NB_PAIR-1:0] acc;
   logic [NB_PAIR-1:0] mcand;
   logic [NB_BITS-1:0] mplier;
   logic [NB_BITS-1:0] hi_q;
   logic [NB_BITS-1:0] lo_q;

   logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
   logic start_ok, start_iter, signed_op, a_neg, b_neg, b_zero;
   logic [NB_BITS-1:0] mag_a, mag_b;

   logic [NB_PAIR-1:0] mul_next;
   logic [NB_BITS:0]   div_shift;
   logic               div_ge;
   logic [NB_BITS-1:0] div_diff;
   logic [NB_PAIR-1:0] div_next;
   logic               early_exit;
   logic               calc_last;
   logic [NB_BITS-1:0] fix_hi, fix_lo;

   assign op_mult  = (i_ope_sel == NB_OPE'(OPC_MULT));
   assign op_multu = (i_ope_sel == NB_OPE'(OPC_MULTU));
   assign op_div   = (i_ope_sel == NB_OPE'(OPC_DIV));
   assign op_divu  = (i_ope_sel == NB_OPE'(OPC_DIVU));
   assign op_mthi  = (i_ope_sel == NB_OPE'(OPC_MTHI));
   assign op_mtlo  = (i_ope_sel == NB_OPE'(OPC_MTLO));

   // Requests are only heard while not busy; DONE counts as idle for issue.
   assign start_ok   = i_start & ((state == ST_IDLE) | (state == ST_DONE));
   assign start_iter = start_ok & (op_mult | op_multu | op_div | op_divu);

   assign signed_op = op_mult | op_div;
   assign a_neg     = signed_op & i_data_a[NB_BITS-1];
   assign b_neg     = signed_op & i_data_b[NB_BITS-1];
   assign b_zero    = (i_data_b == '0);
   assign mag_a     = a_neg ? (~i_data_a + NB_BITS'(1)) : i_data_a;
   assign mag_b     = b_neg ? (~i_data_b + NB_BITS'(1)) : i_data_b;

   assign mul_next = mplier[0] ? (acc + mcand) : acc;

   // Restoring divide: remainder lives in acc's upper half, quotient shifts into the lower half.
   assign div_shift = {acc[NB_PAIR-1:NB_BITS], acc[NB_BITS-1]};
   assign div_ge    = (div_shift >= {1'b0, mcand[NB_BITS-1:0]});
   assign div_diff  = div_shift[NB_BITS-1:0] - mcand[NB_BITS-1:0];
   assign div_next  = {(div_ge ? div_diff : div_shift[NB_BITS-1:0]),
                       acc[NB_BITS-2:0], div_ge};

`ifdef MULDIV_EARLY_TERM_EN
   assign early_exit = ~is_div & ~(|mplier[NB_BITS-1:1]);
`else
   assign early_exit = 1'b0;
`endif

   assign calc_last = (cnt == NB_CNT'(1)) | early_exit;

   muldiv_sign_fix #(
      .NB_BITS (NB_BITS)
   ) u_sign_fix (
      .hi        (acc[NB_PAIR-1:NB_BITS]),
      .lo        (acc[NB_BITS-1:0]),
      .pair_mode (~is_div),
      .neg_hi    (neg_hi),
      .neg_lo    (neg_lo),
      .fixed_hi  (fix_hi),
      .fixed_lo  (fix_lo)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      next_state = state;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_iter) begin
               next_state = ST_CALC;
            end
         end
         ST_CALC: begin
            o_busy = 1'b1;
            if (calc_last) begin
               next_state = ST_FIX;
            end
         end
         ST_FIX: begin
            o_busy     = 1'b1;
            next_state = ST_DONE;
         end
         ST_DONE: begin
            o_done     = 1'b1;
            next_state = start_iter ? ST_CALC : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Operand latching, one iteration per CALC cycle, and HI/LO writes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_hi   <= 1'b0;
         neg_lo   <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         if (start_iter) begin
            cnt    <= NB_CNT'(NB_BITS);
            is_div <= op_div | op_divu;
            if (op_div | op_divu) begin
               acc      <= {{NB_BITS{1'b0}}, mag_a};
               mcand    <= {{NB_BITS{1'b0}}, mag_b};
               mplier   <= '0;
               div_zero <= b_zero;
               neg_hi   <= a_neg;
               neg_lo   <= (a_neg ^ b_neg) & ~b_zero;
            end else begin
               acc      <= '0;
               mcand    <= {{NB_BITS{1'b0}}, mag_a};
               mplier   <= mag_b;
               div_zero <= 1'b0;
               neg_hi   <= a_neg ^ b_neg;
               neg_lo   <= a_neg ^ b_neg;
            end
         end else if (state == ST_CALC) begin
            cnt <= cnt - NB_CNT'(1);
            if (is_div) begin
               acc <= div_next;
            end else begin
               acc    <= mul_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
         end

         if (state == ST_FIX) begin
            hi_q <= fix_hi;
            lo_q <= div_zero ? {NB_BITS{DIV0_LO_BIT}} : fix_lo;
         end else if (start_ok & op_mthi) begin
            hi_q <= i_data_a;
         end else if (start_ok & op_mtlo) begin
            lo_q <= i_data_a;
         end
      end
   end

   assign o_hi = hi_q;
   assign o_lo = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_muldiv;

   localparam int NB_BITS = 32;
   localparam int NB_OPE  = 4;
   localparam int LAT     = NB_BITS + 1;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_start;
   logic [NB_OPE-1:0] i_ope_sel;
   logic [31:0]       i_data_a;
   logic [31:0]       i_data_b;
   logic              o_busy;
   logic              o_done;
   logic [31:0]       o_hi;
   logic [31:0]       o_lo;

   int checks   = 0;
   int failures = 0;

   int          lat_seen;
   int          busy_seen;
   logic        got_done;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[10];

   always #5 i_clk = ~i_clk;

   alu_muldiv #(
      .NB_BITS (NB_BITS),
      .NB_OPE  (NB_OPE)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .i_ope_sel (i_ope_sel),
      .i_data_a  (i_data_a),
      .i_data_b  (i_data_b),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_hi      (o_hi),
      .o_lo      (o_lo)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic.
   task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, p, q, r;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         OP_MULT: begin
            p = sa * sb;
            {hi, lo} = p;
         end
         OP_MULTU: begin
            up = ua * ub;
            {hi, lo} = up;
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               q  = sa / sb;
               r  = sa % sb;
               lo = q[31:0];
               hi = r[31:0];
            end
         end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               up = ua / ub;
               lo = up[31:0];
               up = ua % ub;
               hi = up[31:0];
            end
         end
      endcase
   endtask

   // Issue one iterative op (caller sits just after a negedge) and wait for o_done.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      i_start   = 1'b1;
      i_ope_sel = op;
      i_data_a  = a;
      i_data_b  = b;
      busy_seen = 0;
      lat_seen  = -1;
      got_done  = 1'b0;
      for (int j = 0; j < 120; j++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (o_busy) busy_seen++;
         if (o_done) begin
            lat_seen = j;
            res_hi   = o_hi;
            res_lo   = o_lo;
            got_done = 1'b1;
            break;
         end
      end
      if (!got_done) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_timeout: got no o_done, want o_done within 120 cycles (op=%0d)", op);
         res_hi = 32'hX;
         res_lo = 32'hX;
      end
   endtask

   task automatic issueMove(input logic [3:0] op, input logic [31:0] data);
      i_start   = 1'b1;
      i_ope_sel = op;
      i_data_a  = data;
      i_data_b  = 32'd0;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got simulation still running, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] eh, el, ra, rb;
      logic [3:0]  rop;
      int          done_cnt;
      logic        early_ok;

      vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
      vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002};
      vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[8] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[9] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_ope_sel = '0;
      i_data_a  = '0;
      i_data_b  = '0;
      repeat (2) @(negedge i_clk);
      checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("reset_done", {31'd0, o_done}, 32'd0);
      checkOutput("reset_hi", o_hi, 32'd0);
      checkOutput("reset_lo", o_lo, 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // Undefined opcode is a no-op.
      issueMove(4'b1001, 32'hDEAD_BEEF);
      checkOutput("undef_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("undef_hi", o_hi, 32'd0);
      checkOutput("undef_lo", o_lo, 32'd0);

      // MTLO / MTHI while idle.
      issueMove(OP_MTLO, 32'h0000_ABCD);
      checkOutput("mtlo_lo", o_lo, 32'h0000_ABCD);
      checkOutput("mtlo_done", {31'd0, o_done}, 32'd0);
      checkOutput("mtlo_busy", {31'd0, o_busy}, 32'd0);
      @(negedge i_clk);
      checkOutput("mtlo_done_next", {31'd0, o_done}, 32'd0);
      issueMove(OP_MTHI, 32'h0000_5A5A);
      checkOutput("mthi_hi", o_hi, 32'h0000_5A5A);
      checkOutput("mthi_lo_kept", o_lo, 32'h0000_ABCD);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("vec%0d_hi", i), res_hi, vecs[i].exp_hi);
         checkOutput($sformatf("vec%0d_lo", i), res_lo, vecs[i].exp_lo);
`ifdef MULDIV_EARLY_TERM_EN
         if (vecs[i].op == OP_MULT || vecs[i].op == OP_MULTU) begin
            checkOutput($sformatf("vec%0d_lat_bound", i), {31'd0, (lat_seen <= LAT && lat_seen >= 2)}, 32'd1);
         end else begin
            checkOutput($sformatf("vec%0d_latency", i), lat_seen, LAT);
         end
         checkOutput($sformatf("vec%0d_busy", i), busy_seen, lat_seen);
`else
         checkOutput($sformatf("vec%0d_latency", i), lat_seen, LAT);
         checkOutput($sformatf("vec%0d_busy", i), busy_seen, LAT);
`endif
         @(negedge i_clk);
         checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, o_done}, 32'd0);
      end

      // MTHI issued five cycles into a MULTU must be ignored.
      issueMove(OP_MTHI, 32'h0000_5555);
      i_start   = 1'b1;
      i_ope_sel = OP_MULTU;
      i_data_a  = 32'd7;
      i_data_b  = 32'd6;
      got_done  = 1'b0;
      for (int j = 0; j < 120; j++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (j == 4) begin
            i_start   = 1'b1;
            i_ope_sel = OP_MTHI;
            i_data_a  = 32'h0000_1234;
         end
         if (j == 6) checkOutput("busy_mthi_hold", o_hi, 32'h0000_5555);
         if (o_done) begin
            got_done = 1'b1;
            checkOutput("busy_mthi_hi", o_hi, 32'd0);
            checkOutput("busy_mthi_lo", o_lo, 32'd42);
            break;
         end
      end
      checkOutput("busy_mthi_done_seen", {31'd0, got_done}, 32'd1);
      @(negedge i_clk);
      checkOutput("busy_mthi_hi_after", o_hi, 32'd0);

      // Reset during CALC discards everything.
      issueMove(OP_MTHI, 32'h0000_5555);
      issueMove(OP_MTLO, 32'h0000_7777);
      i_start   = 1'b1;
      i_ope_sel = OP_MULT;
      i_data_a  = 32'h0000_0100;
      i_data_b  = 32'h0000_0100;
      for (int j = 0; j < 11; j++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (j == 9) i_rst = 1'b1;
      end
      i_rst = 1'b0;
      checkOutput("rst_mid_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("rst_mid_done", {31'd0, o_done}, 32'd0);
      checkOutput("rst_mid_hi", o_hi, 32'd0);
      checkOutput("rst_mid_lo", o_lo, 32'd0);
      done_cnt = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge i_clk);
         if (o_done) done_cnt++;
      end
      checkOutput("rst_mid_no_done", done_cnt, 0);
      applyStimulus(OP_MULT, 32'd2, 32'd3);
      checkOutput("post_rst_lo", res_lo, 32'd6);
      checkOutput("post_rst_hi", res_hi, 32'd0);
      @(negedge i_clk);

      // Small multiplier: early exit when enabled, full latency otherwise.
      applyStimulus(OP_MULTU, 32'd7, 32'd1);
      checkOutput("small_mul_lo", res_lo, 32'd7);
      checkOutput("small_mul_hi", res_hi, 32'd0);
`ifdef MULDIV_EARLY_TERM_EN
      early_ok = (lat_seen >= 0) && (lat_seen < LAT);
      checkOutput("small_mul_early", {31'd0, early_ok}, 32'd1);
`else
      early_ok = 1'b0;
      checkOutput("small_mul_latency", lat_seen, LAT);
`endif

      // Randomized back-to-back operations (each new start lands in the DONE cycle).
      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: ra = 32'h8000_0000;
            1: rb = 32'd0;
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'($urandom_range(1, 15));
            4: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         refModel(rop, ra, rb, eh, el);
         applyStimulus(rop, ra, rb);
         checkOutput($sformatf("rand%0d_op%0d_hi", n, rop), res_hi, eh);
         checkOutput($sformatf("rand%0d_op%0d_lo", n, rop), res_lo, el);
      end
      @(negedge i_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
